counter_modulo_down_sync: RTL and testbench

// - Synchronous modulo-N down counter with parallel load, enable and a borrow/terminal-count output.
// - It counts in the opposite direction to the ripple up-counters in the experiment set.
// - All flip-flops share one clock, so there is no ripple skew.
// - Serves as the countdown/timer element; borrow_out cascades into the next stage's enable.

---
 rtl/counter_modulo_down_sync.sv | 128 ++++++++++++
 tb/tb_counter_modulo_down_sync.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/counter_modulo_down_sync.sv
// ---------------------------------------------------------------------------
// counter_modulo_down_sync
// Synchronous modulo-MODULUS down counter with parallel load, count enable,
// a combinational borrow output for cascading, and registered single-cycle
// wrap / load-error pulses. Every flop is clocked by clockpulse.
//
// Parameters:
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1, legal 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   clockpulse  in   1      clock, rising edge active
//   clear       in   1      synchronous active-high reset
//   enable      in   1      advance one step per enabled edge
//   load        in   1      synchronous parallel load (priority over enable)
//   data_load   in   WIDTH  value captured on load (clamped to MODULUS-1)
//   signal_q    out  WIDTH  registered count
//   signal_q_   out  WIDTH  bitwise complement of signal_q
//   borrow_out  out  1      enable && signal_q == 0 (down direction only)
//   wrap_pulse  out  1      registered, high after a wrap
//   load_error  out  1      registered, high after an out-of-range load
//
// Optional feature macro: COUNTER_UPDOWN_EN
//   Adds count_up (in) selecting increment, and carry_out (out) which is
//   enable && count_up && signal_q == MODULUS-1.
// ---------------------------------------------------------------------------
module counter_modulo_down_sync #(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data_load,
`ifdef COUNTER_UPDOWN_EN
  input  logic             count_up,
  output logic             carry_out,
`endif
  output logic [WIDTH-1:0] signal_q,
  output logic [WIDTH-1:0] signal_q_,
  output logic             borrow_out,
  output logic             wrap_pulse,
  output logic             load_error
);

  // Reject illegal configurations at elaboration.
  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("counter_modulo_down_sync: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  // Terminal value, truncated to WIDTH so MODULUS == 2**WIDTH gives all ones.
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             lerr_q,  lerr_d;
  logic             up_s;

`ifdef COUNTER_UPDOWN_EN
  assign up_s = count_up;
`else
  assign up_s = 1'b0;
`endif

  // Next-state: load > enable > hold; pulses default low so they last one cycle.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    if (load) begin
      // data_load > MAX_C is the WIDTH-bit form of data_load >= MODULUS.
      if (data_load > MAX_C) begin
        count_d = MAX_C;
        lerr_d  = 1'b1;
      end else begin
        count_d = data_load;
      end
    end else if (enable) begin
      if (count_q > MAX_C) begin
        // Unreachable state recovery: park on the terminal value, no pulse.
        count_d = MAX_C;
      end else if (up_s) begin
        if (count_q == MAX_C) begin
          count_d = ZERO_C;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + ONE_C;
        end
      end else begin
        if (count_q == ZERO_C) begin
          count_d = MAX_C;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - ONE_C;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous clear taking priority over everything.
  always_ff @(posedge clockpulse) begin
    if (clear) begin
      count_q <= ZERO_C;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign signal_q   = count_q;
  assign signal_q_  = ~count_q;
  assign wrap_pulse = wrap_q;
  assign load_error = lerr_q;
  // Combinational so a downstream stage can use it as its enable in the same cycle.
  assign borrow_out = enable && !up_s && (count_q == ZERO_C);
`ifdef COUNTER_UPDOWN_EN
  assign carry_out  = enable && count_up && (count_q == MAX_C);
`endif

endmodule

// File: tb/tb_counter_modulo_down_sync.sv
module tb_counter_modulo_down_sync;

  typedef struct {
    int         sel;
    logic [1:0] q;
    logic       w;
    logic       le;
    logic       b;
    logic       c;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic clk = 1'b0;

  always #5 clk = ~clk;

  // Instance A: MODULUS=4
  logic       clr4 = 1'b1, ld4 = 1'b0, en4 = 1'b0, up4 = 1'b0;
  logic [1:0] dl4 = 2'd0, q4, qn4;
  logic       b4, w4, le4, c4;
  // Instance B: MODULUS=3
  logic       clr3 = 1'b1, ld3 = 1'b0, en3 = 1'b0, up3 = 1'b0;
  logic [1:0] dl3 = 2'd0, q3, qn3;
  logic       b3, w3, le3, c3;

`ifndef COUNTER_UPDOWN_EN
  assign c4 = 1'b0;
  assign c3 = 1'b0;
`endif

  counter_modulo_down_sync #(.WIDTH(2), .MODULUS(4)) dut4 (
    .clockpulse(clk), .clear(clr4), .enable(en4), .load(ld4), .data_load(dl4),
`ifdef COUNTER_UPDOWN_EN
    .count_up(up4), .carry_out(c4),
`endif
    .signal_q(q4), .signal_q_(qn4), .borrow_out(b4), .wrap_pulse(w4), .load_error(le4)
  );

  counter_modulo_down_sync #(.WIDTH(2), .MODULUS(3)) dut3 (
    .clockpulse(clk), .clear(clr3), .enable(en3), .load(ld3), .data_load(dl3),
`ifdef COUNTER_UPDOWN_EN
    .count_up(up3), .carry_out(c3),
`endif
    .signal_q(q3), .signal_q_(qn3), .borrow_out(b3), .wrap_pulse(w3), .load_error(le3)
  );

  task automatic chk(input string nm, input string f, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, f, act, exp);
    end
  endtask

  // Drive one edge's inputs on the falling edge, then queue the expected result.
  task automatic step(input int sel, input logic clr, input logic ld, input logic en,
                      input logic [1:0] dl, input logic up,
                      input logic [1:0] eq, input logic ew, input logic el, input string nm);
    exp_t e;
    int   maxv;
    @(negedge clk);
    if (sel == 4) begin
      clr4 = clr; ld4 = ld; en4 = en; dl4 = dl; up4 = up;
    end else begin
      clr3 = clr; ld3 = ld; en3 = en; dl3 = dl; up3 = up;
    end
    @(posedge clk);
    #1;
    maxv  = sel - 1;
    e.sel = sel;
    e.q   = eq;
    e.w   = ew;
    e.le  = el;
    e.b   = en && !up && (eq == 2'd0);
    e.c   = en && up && (int'(eq) == maxv);
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // Monitor: after each edge, pop the pending expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel == 4) begin
          chk(e.nm, "q",    {6'd0, q4},  {6'd0, e.q});
          chk(e.nm, "qn",   {6'd0, qn4}, {6'd0, ~e.q});
          chk(e.nm, "wrap", {7'd0, w4},  {7'd0, e.w});
          chk(e.nm, "lerr", {7'd0, le4}, {7'd0, e.le});
          chk(e.nm, "borrow", {7'd0, b4}, {7'd0, e.b});
`ifdef COUNTER_UPDOWN_EN
          chk(e.nm, "carry", {7'd0, c4}, {7'd0, e.c});
`endif
        end else begin
          chk(e.nm, "q",    {6'd0, q3},  {6'd0, e.q});
          chk(e.nm, "qn",   {6'd0, qn3}, {6'd0, ~e.q});
          chk(e.nm, "wrap", {7'd0, w3},  {7'd0, e.w});
          chk(e.nm, "lerr", {7'd0, le3}, {7'd0, e.le});
          chk(e.nm, "borrow", {7'd0, b3}, {7'd0, e.b});
`ifdef COUNTER_UPDOWN_EN
          chk(e.nm, "carry", {7'd0, c3}, {7'd0, e.c});
`endif
        end
      end
    end
  end

  initial begin
    // Reset with every other request asserted
    step(4, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, "rst0");
    step(4, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, "rst1");
    // Countdown from 0 for 5 edges
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 1'b0, "dn1");
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, "dn2");
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, "dn3");
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, "dn4");
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 1'b0, "dn5");
    // Reach q=1, then load has priority over enable
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, "dn6");
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, "dn7");
    step(4, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, 1'b0, "ldpri");
    for (int i = 0; i < 3; i++)
      step(4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, "hold");
    // Clear mid-count overrides enable, then release
    step(4, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, "midclr");
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 1'b0, "relclr");
    step(4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0, "wrapoff");
    step(4, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, "ld0");
    step(4, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0, "ld3");
    // MODULUS=3: out-of-range load clamps and flags for one cycle
    step(3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, "m3rst");
    step(3, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 2'd2, 1'b0, 1'b1, "m3lderr");
    step(3, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, "m3ld0");
    step(3, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0, "m3wrap");
    step(3, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, "m3dn");
    step(3, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 2'd2, 1'b0, 1'b1, "m3lderr2");
    step(3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, "m3hold");
`ifdef COUNTER_UPDOWN_EN
    // Up-count from 0: q 1,2,3,0 with carry at 3 and wrap after the 0 step
    step(4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, "uprst");
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, "up1");
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, "up2");
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, "up3");
    step(4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, "up4");
`endif
    // Let the monitor drain the queue, bounded
    repeat (3) @(posedge clk);
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
